hazard3_bus_arb: RTL and testbench

- Parametrised N-master to 1-slave arbiter for the Hazard3 split address-phase/data-phase bus (aph/dph handshake).
- Merges the core's I and D ports, and optionally DMA/debug masters, onto one downstream memory port.
- Supports one outstanding data phase, pipelined with the next address phase.
- Selectable fixed-priority or round-robin arbitration with grant locking across stalled address phases.

---
 rtl/hazard3_bus_arb_if.sv | 41 ++++
 rtl/hazard3_bus_arb.sv | 96 +++++++++
 tb/tb_hazard3_bus_arb.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/hazard3_bus_arb_if.sv
// Bundle of the upstream (per-master, packed) and downstream Hazard3 aph/dph bus signals.
// "master" is the arbiter's view; "slave" is the surrounding system (upstream masters + memory).
interface hazard3_bus_arb_if #(
  parameter int N_MASTERS = 2,
  parameter int W_ADDR    = 32,
  parameter int W_DATA    = 32
);
  logic [N_MASTERS-1:0]        m_aph_req;
  logic [N_MASTERS*W_ADDR-1:0] m_haddr;
  logic [N_MASTERS*3-1:0]      m_hsize;
  logic [N_MASTERS-1:0]        m_hwrite;
  logic [N_MASTERS*W_DATA-1:0] m_wdata;
  logic [N_MASTERS-1:0]        m_aph_ready;
  logic [N_MASTERS-1:0]        m_dph_ready;
  logic [N_MASTERS-1:0]        m_dph_err;
  logic [W_DATA-1:0]           m_rdata;

  logic                        s_aph_req;
  logic [W_ADDR-1:0]           s_haddr;
  logic [2:0]                  s_hsize;
  logic                        s_hwrite;
  logic [W_DATA-1:0]           s_wdata;
  logic                        s_aph_ready;
  logic                        s_dph_ready;
  logic                        s_dph_err;
  logic [W_DATA-1:0]           s_rdata;

  modport master (
    input  m_aph_req, m_haddr, m_hsize, m_hwrite, m_wdata,
    input  s_aph_ready, s_dph_ready, s_dph_err, s_rdata,
    output m_aph_ready, m_dph_ready, m_dph_err, m_rdata,
    output s_aph_req, s_haddr, s_hsize, s_hwrite, s_wdata
  );

  modport slave (
    output m_aph_req, m_haddr, m_hsize, m_hwrite, m_wdata,
    output s_aph_ready, s_dph_ready, s_dph_err, s_rdata,
    input  m_aph_ready, m_dph_ready, m_dph_err, m_rdata,
    input  s_aph_req, s_haddr, s_hsize, s_hwrite, s_wdata
  );
endinterface

// File: rtl/hazard3_bus_arb.sv
// N-master to 1-slave arbiter for the Hazard3 split aph/dph bus: one outstanding data phase,
// fixed-priority or round-robin grant, grant held while an address phase is stalled.
module hazard3_bus_arb #(
  parameter int N_MASTERS = 2,
  parameter int W_ADDR    = 32,
  parameter int W_DATA    = 32,
  parameter int ARB_MODE  = 0
) (
  input  logic                clk,
  input  logic                rst,
  hazard3_bus_arb_if.master   bus
);
  localparam int W_IDX = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  logic              lock_vld_reg;
  logic [W_IDX-1:0]  lock_idx_reg;
  logic [W_IDX-1:0]  rr_last_reg;
  logic              dph_vld_reg;
  logic [W_IDX-1:0]  dph_owner_reg;

  logic [W_IDX-1:0]  grant;
  logic              any_req;
  logic              accept;
  logic              rr_found;
  int                rr_idx;

  logic [W_ADDR-1:0] haddr_arr [N_MASTERS];
  logic [2:0]        hsize_arr [N_MASTERS];
  logic [W_DATA-1:0] wdata_arr [N_MASTERS];

  assign any_req = |bus.m_aph_req;
  assign accept  = any_req & bus.s_aph_ready;

  // A locked grant wins outright so a stalled address never switches master.
  always_comb begin
    grant    = '0;
    rr_found = 1'b0;
    rr_idx   = 0;
    if (lock_vld_reg) begin
      grant = lock_idx_reg;
    end else if (ARB_MODE == 0) begin
      for (int i = N_MASTERS - 1; i >= 0; i--) begin
        if (bus.m_aph_req[i]) grant = W_IDX'(i);
      end
    end else begin
      for (int k = 1; k <= N_MASTERS; k++) begin
        rr_idx = (int'(rr_last_reg) + k) % N_MASTERS;
        if (!rr_found && bus.m_aph_req[rr_idx]) begin
          grant    = W_IDX'(rr_idx);
          rr_found = 1'b1;
        end
      end
    end
  end

  for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_master
    assign haddr_arr[gi]          = bus.m_haddr[gi*W_ADDR +: W_ADDR];
    assign hsize_arr[gi]          = bus.m_hsize[gi*3 +: 3];
    assign wdata_arr[gi]          = bus.m_wdata[gi*W_DATA +: W_DATA];
    assign bus.m_aph_ready[gi]    = accept & (grant == W_IDX'(gi));
    assign bus.m_dph_ready[gi]    = dph_vld_reg & bus.s_dph_ready & (dph_owner_reg == W_IDX'(gi));
    assign bus.m_dph_err[gi]      = dph_vld_reg & bus.s_dph_err & (dph_owner_reg == W_IDX'(gi));
  end

  assign bus.s_aph_req = any_req;
  assign bus.s_haddr   = haddr_arr[grant];
  assign bus.s_hsize   = hsize_arr[grant];
  assign bus.s_hwrite  = bus.m_hwrite[grant];
  assign bus.s_wdata   = wdata_arr[dph_owner_reg];
  assign bus.m_rdata   = bus.s_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_vld_reg  <= 1'b0;
      lock_idx_reg  <= '0;
      rr_last_reg   <= W_IDX'(N_MASTERS - 1);
      dph_vld_reg   <= 1'b0;
      dph_owner_reg <= '0;
    end else begin
      if (accept) begin
        lock_vld_reg <= 1'b0;
      end else if (any_req) begin
        lock_vld_reg <= 1'b1;
        lock_idx_reg <= grant;
      end
      // Accept wins over completion: a same-cycle handoff keeps dph_vld and moves ownership.
      if (accept) begin
        rr_last_reg   <= grant;
        dph_vld_reg   <= 1'b1;
        dph_owner_reg <= grant;
      end else if (bus.s_dph_ready) begin
        dph_vld_reg <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_hazard3_bus_arb.sv
// Directed bench: fixed-priority N=2 and round-robin N=3 arbiters, scoreboard of expected dph owners.
module tb_hazard3_bus_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard3_bus_arb_if #(.N_MASTERS(2), .W_ADDR(32), .W_DATA(32)) bus_a ();
  hazard3_bus_arb_if #(.N_MASTERS(3), .W_ADDR(32), .W_DATA(32)) bus_b ();

  hazard3_bus_arb #(.N_MASTERS(2), .W_ADDR(32), .W_DATA(32), .ARB_MODE(0)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.master)
  );
  hazard3_bus_arb #(.N_MASTERS(3), .W_ADDR(32), .W_DATA(32), .ARB_MODE(1)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.master)
  );

  int checks = 0;
  int failures = 0;
  int a_q[$];
  int b_q[$];
  logic [31:0] a_addr [2];
  logic [31:0] a_wd   [2];
  logic        a_hw   [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle on instance A: drive, settle, compare against the directed expectation.
  task automatic a_step(input logic [1:0] req, input logic aph_rdy, input logic dph_rdy,
                        input logic err, input int exp_grant);
    int owner;
    logic [31:0] rd;
    @(posedge clk); #1;
    rd = $urandom;
    bus_a.m_aph_req   = req;
    bus_a.m_haddr     = {a_addr[1], a_addr[0]};
    bus_a.m_hwrite    = {a_hw[1], a_hw[0]};
    bus_a.m_wdata     = {a_wd[1], a_wd[0]};
    bus_a.m_hsize     = 6'b010_010;
    bus_a.s_aph_ready = aph_rdy;
    bus_a.s_dph_ready = dph_rdy;
    bus_a.s_dph_err   = err;
    bus_a.s_rdata     = rd;
    #1;
    if (a_q.size() > 0) begin
      owner = a_q[0];
      chk("s_wdata", bus_a.s_wdata, a_wd[owner]);
      chk("m_dph_ready", bus_a.m_dph_ready, dph_rdy ? (64'(1) << owner) : 64'(0));
      chk("m_dph_err", bus_a.m_dph_err, (dph_rdy && err) ? (64'(1) << owner) : 64'(0));
      if (dph_rdy) begin
        chk("m_rdata", bus_a.m_rdata, rd);
        void'(a_q.pop_front());
      end
    end else begin
      chk("m_dph_ready_idle", bus_a.m_dph_ready, 0);
      chk("m_dph_err_idle", bus_a.m_dph_err, 0);
    end
    chk("s_aph_req", bus_a.s_aph_req, req != 2'b00);
    chk("m_aph_ready", bus_a.m_aph_ready,
        (req != 2'b00 && aph_rdy) ? (64'(1) << exp_grant) : 64'(0));
    if (req != 2'b00) begin
      chk("s_haddr", bus_a.s_haddr, a_addr[exp_grant]);
      chk("s_hwrite", bus_a.s_hwrite, a_hw[exp_grant]);
      if (aph_rdy) a_q.push_back(exp_grant);
    end
    $display("A req=%b aph_rdy=%b dph_rdy=%b err=%b grant_exp=%0d haddr=%h aph_ready=%b dph_ready=%b",
             req, aph_rdy, dph_rdy, err, exp_grant, bus_a.s_haddr, bus_a.m_aph_ready, bus_a.m_dph_ready);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    int e;
    a_addr[0] = 32'h100; a_addr[1] = 32'h200;
    a_wd[0] = 32'h1111_1111; a_wd[1] = 32'hDEAD_BEEF;
    a_hw[0] = 1'b0; a_hw[1] = 1'b1;
    bus_a.m_aph_req = '0; bus_a.m_haddr = '0; bus_a.m_hsize = '0; bus_a.m_hwrite = '0;
    bus_a.m_wdata = '0; bus_a.s_aph_ready = 1'b0; bus_a.s_dph_ready = 1'b0;
    bus_a.s_dph_err = 1'b0; bus_a.s_rdata = '0;
    bus_b.m_aph_req = '0; bus_b.m_haddr = {32'h3000, 32'h2000, 32'h1000}; bus_b.m_hsize = '0;
    bus_b.m_hwrite = '0; bus_b.m_wdata = '0; bus_b.s_aph_ready = 1'b0; bus_b.s_dph_ready = 1'b1;
    bus_b.s_dph_err = 1'b0; bus_b.s_rdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_lock_vld", dut_a.lock_vld_reg, 0);
    chk("rst_dph_vld", dut_a.dph_vld_reg, 0);
    chk("rst_rr_last_b", dut_b.rr_last_reg, 2);
    chk("rst_s_aph_req", bus_a.s_aph_req, 0);
    chk("rst_m_aph_ready", bus_a.m_aph_ready, 0);
    chk("rst_m_dph_ready", bus_a.m_dph_ready, 0);
    chk("rst_m_dph_err", bus_a.m_dph_err, 0);
    $display("reset checked");
    rst = 1'b0;

    // Fixed priority: master 0 starves master 1 until it drops its request
    a_step(2'b11, 1'b1, 1'b1, 1'b0, 0);
    a_step(2'b11, 1'b1, 1'b1, 1'b0, 0);
    a_step(2'b11, 1'b1, 1'b1, 1'b0, 0);
    a_step(2'b10, 1'b1, 1'b1, 1'b0, 1);
    a_step(2'b00, 1'b1, 1'b1, 1'b0, 0);

    // Stall lock: master 1 stalled, master 0 arrives mid-stall, must wait
    a_addr[1] = 32'h0000_1000;
    a_step(2'b10, 1'b0, 1'b0, 1'b0, 1);
    a_step(2'b11, 1'b0, 1'b0, 1'b0, 1);
    a_step(2'b11, 1'b0, 1'b0, 1'b0, 1);
    a_step(2'b11, 1'b1, 1'b0, 1'b0, 1);
    a_step(2'b01, 1'b1, 1'b1, 1'b0, 0);
    a_step(2'b00, 1'b0, 1'b1, 1'b0, 0);

    // Pipelined handoff (read 0x100 by m0, then write 0x200 by m1) and error routing
    a_addr[1] = 32'h200;
    a_step(2'b01, 1'b1, 1'b0, 1'b0, 0);
    a_step(2'b10, 1'b1, 1'b1, 1'b0, 1);
    a_step(2'b00, 1'b0, 1'b0, 1'b0, 0);
    a_step(2'b00, 1'b0, 1'b1, 1'b1, 0);
    a_step(2'b00, 1'b0, 1'b1, 1'b0, 0);

    // Round-robin on instance B: 0,1,2,0,1,2 with rr_last following each accept
    prev = 2;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("rr_last", dut_b.rr_last_reg, prev);
      bus_b.m_aph_req = 3'b111;
      bus_b.s_aph_ready = 1'b1;
      b_q.push_back(k % 3);
      #1;
      e = b_q.pop_front();
      chk("rr_grant", bus_b.m_aph_ready, 64'(1) << e);
      chk("rr_haddr", bus_b.s_haddr, 32'h1000 * (e + 1));
      $display("B step=%0d grant_exp=%0d aph_ready=%b haddr=%h", k, e, bus_b.m_aph_ready, bus_b.s_haddr);
      prev = e;
    end
    @(posedge clk); #1;
    bus_b.m_aph_req = '0;

    // Reset mid-stall: build lock_vld=1 and dph_vld=1, then reset
    a_step(2'b01, 1'b1, 1'b0, 1'b0, 0);
    a_step(2'b10, 1'b0, 1'b0, 1'b0, 1);
    @(posedge clk); #1;
    chk("pre_rst_lock_vld", dut_a.lock_vld_reg, 1);
    chk("pre_rst_dph_vld", dut_a.dph_vld_reg, 1);
    rst = 1'b1;
    bus_a.m_aph_req = 2'b11;
    @(posedge clk); #1;
    chk("midrst_lock_vld", dut_a.lock_vld_reg, 0);
    chk("midrst_dph_vld", dut_a.dph_vld_reg, 0);
    chk("midrst_rr_last_a", dut_a.rr_last_reg, 1);
    chk("midrst_rr_last_b", dut_b.rr_last_reg, 2);
    $display("mid-stall reset checked");
    rst = 1'b0;
    a_q.delete();
    a_step(2'b11, 1'b1, 1'b0, 1'b0, 0);
    bus_b.m_aph_req = 3'b110;
    bus_b.s_aph_ready = 1'b1;
    #1;
    chk("post_rst_rr_grant", bus_b.m_aph_ready, 3'b010);
    $display("B post-reset aph_ready=%b", bus_b.m_aph_ready);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
